// File: rtl/battleship_pkg.sv
// Shared cell codes, game-phase encoding and a width helper for the battleship core.
package battleship_pkg;

  localparam logic [1:0] CELL_UNKNOWN = 2'b00;
  localparam logic [1:0] CELL_MISS    = 2'b01;
  localparam logic [1:0] CELL_HIT     = 2'b10;
  localparam logic [1:0] CELL_SUNK    = 2'b11;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_LOAD = 3'd1,
    PH_PLAY = 3'd2,
    PH_SINK = 3'd3,
    PH_WIN  = 3'd4,
    PH_LOSE = 3'd5
  } phase_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned t = 1; t < v; t = t << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce_edge.sv
// Fire-button conditioning: 2-flop synchroniser, DB_CYCLES-sample debounce and
// a one-cycle pulse on each rising edge of the debounced level.
module btn_debounce_edge
  import battleship_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press_pulse
);

  localparam int unsigned CNT_W = (clog2(DB_CYCLES) < 1) ? 1 : clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Counter runs while the synchronised sample disagrees with the stable level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt    <= '0;
        r_stable <= r_sync2;
        r_press  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign press_pulse = r_press;

endmodule

// File: rtl/battleship_game_core.sv
// Battleship game-state engine: loads a ship-ID map, resolves shots at the
// cursor, tracks per-ship hits, marks sunk ships and decides win/lose.
module battleship_game_core
  import battleship_pkg::*;
#(
  parameter int unsigned ROWS       = 10,
  parameter int unsigned COLS       = 10,
  parameter int unsigned NUM_SHIPS  = 5,
  parameter int unsigned ID_W       = 3,
  parameter int unsigned MAX_TURNS  = 20,
  parameter int unsigned TURN_W     = 5,
  parameter int unsigned SHIP_W     = 3,
  parameter int unsigned DB_CYCLES  = 1000000,
  parameter int unsigned AUTO_START = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      btn_c,
  input  logic                      start,
  input  logic [3:0]                sprite_row,
  input  logic [3:0]                sprite_col,
  input  logic [ROWS*COLS*ID_W-1:0] ship_map_flat,
  output logic [2*ROWS*COLS-1:0]    cell_status_flat,
  output logic [TURN_W-1:0]         turns_left,
  output logic [SHIP_W-1:0]         ships_remaining,
  output logic [2:0]                game_phase,
  output logic                      busy,
  output logic                      hit_pulse,
  output logic                      miss_pulse,
  output logic                      sunk_pulse,
  output logic                      dup_pulse
);

  localparam int unsigned CELLS   = ROWS * COLS;
  localparam int unsigned IDX_W   = (clog2(CELLS) < 1) ? 1 : clog2(CELLS);
  localparam int unsigned CNT_W   = clog2(CELLS + 1);
  localparam int unsigned NUM_IDS = 1 << ID_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

  phase_e                 r_state;
  logic                   r_busy, r_hit, r_miss, r_sunk, r_dup;
  logic [2*CELLS-1:0]     r_cells;
  logic [CELLS*ID_W-1:0]  r_map;
  logic [TURN_W-1:0]      r_turns;
  logic [SHIP_W-1:0]      r_ships;
  logic [CNT_W-1:0]       r_cnt [NUM_IDS];
  logic [IDX_W-1:0]       r_scan;
  logic [ID_W-1:0]        r_sink_id;

  logic                   w_fire, w_in_range, w_fire_ship, w_scan_ship, w_go_load;
  logic [IDX_W-1:0]       w_fire_idx;
  logic [ID_W-1:0]        w_fire_id, w_scan_id;
  logic [1:0]             w_fire_code;
  logic [TURN_W-1:0]      w_turns_dec;
  logic [SHIP_W-1:0]      w_load_ships;

  btn_debounce_edge #(.DB_CYCLES(DB_CYCLES)) u_fire (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_c),
    .press_pulse (w_fire)
  );

  assign w_in_range  = (32'(sprite_row) < ROWS) && (32'(sprite_col) < COLS);
  assign w_fire_idx  = IDX_W'(32'(sprite_row) * COLS + 32'(sprite_col));
  assign w_fire_id   = r_map[w_fire_idx*ID_W +: ID_W];
  assign w_fire_code = r_cells[2*w_fire_idx +: 2];
  assign w_fire_ship = (w_fire_id != '0) && (32'(w_fire_id) <= NUM_SHIPS);
  assign w_scan_id   = r_map[r_scan*ID_W +: ID_W];
  assign w_scan_ship = (w_scan_id != '0) && (32'(w_scan_id) <= NUM_SHIPS);
  assign w_turns_dec = (r_turns != '0) ? r_turns - TURN_W'(1) : r_turns;
  assign w_go_load   = (start && (r_state != PH_IDLE) && (r_state != PH_LOAD)) ||
                       ((r_state == PH_IDLE) && (start || (AUTO_START != 0)));

  // Ship count on the final LOAD cycle, including the cell scanned in that cycle
  always_comb begin
    w_load_ships = '0;
    for (int unsigned s = 1; s <= NUM_SHIPS; s++) begin
      if ((r_cnt[ID_W'(s)] != '0) || (32'(w_scan_id) == s))
        w_load_ships = w_load_ships + SHIP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= PH_IDLE;
      r_busy    <= 1'b0;
      r_hit     <= 1'b0;
      r_miss    <= 1'b0;
      r_sunk    <= 1'b0;
      r_dup     <= 1'b0;
      r_cells   <= '0;
      r_map     <= '0;
      r_turns   <= '0;
      r_ships   <= '0;
      r_scan    <= '0;
      r_sink_id <= '0;
      for (int i = 0; i < NUM_IDS; i++) r_cnt[i] <= '0;
    end else begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      r_sunk <= 1'b0;
      r_dup  <= 1'b0;
      if (w_go_load) begin
        r_state <= PH_LOAD;
        r_busy  <= 1'b1;
        r_map   <= ship_map_flat;
        r_cells <= '0;
        r_turns <= TURN_W'(MAX_TURNS);
        r_ships <= '0;
        r_scan  <= '0;
        for (int i = 0; i < NUM_IDS; i++) r_cnt[i] <= '0;
      end else begin
        case (r_state)
          PH_LOAD: begin
            if (w_scan_ship) r_cnt[w_scan_id] <= r_cnt[w_scan_id] + CNT_W'(1);
            if (r_scan == LAST_IDX) begin
              r_ships <= w_load_ships;
              r_state <= PH_PLAY;
              r_busy  <= 1'b0;
              r_scan  <= '0;
            end else begin
              r_scan <= r_scan + IDX_W'(1);
            end
          end
          PH_PLAY: begin
            if (w_fire && w_in_range) begin
              if (w_fire_code != CELL_UNKNOWN) begin
                r_dup <= 1'b1;
              end else if (!w_fire_ship) begin
                r_cells[2*w_fire_idx +: 2] <= CELL_MISS;
                r_turns <= w_turns_dec;
                r_miss  <= 1'b1;
                if (r_ships == '0)            r_state <= PH_WIN;
                else if (w_turns_dec == '0)   r_state <= PH_LOSE;
              end else begin
                r_cells[2*w_fire_idx +: 2] <= CELL_HIT;
                r_turns <= w_turns_dec;
                r_hit   <= 1'b1;
                if (r_cnt[w_fire_id] != '0) r_cnt[w_fire_id] <= r_cnt[w_fire_id] - CNT_W'(1);
                if (r_cnt[w_fire_id] == CNT_W'(1)) begin
                  if (r_ships != '0) r_ships <= r_ships - SHIP_W'(1);
                  r_sunk    <= 1'b1;
                  r_sink_id <= w_fire_id;
                  r_state   <= PH_SINK;
                  r_busy    <= 1'b1;
                  r_scan    <= '0;
                end else if (r_ships == '0) begin
                  r_state <= PH_WIN;
                end else if (w_turns_dec == '0) begin
                  r_state <= PH_LOSE;
                end
              end
            end
          end
          PH_SINK: begin
            if (w_scan_id == r_sink_id) r_cells[2*r_scan +: 2] <= CELL_SUNK;
            if (r_scan == LAST_IDX) begin
              r_busy <= 1'b0;
              r_scan <= '0;
              // Win outranks lose when the last turn sinks the last ship
              if (r_ships == '0)       r_state <= PH_WIN;
              else if (r_turns == '0)  r_state <= PH_LOSE;
              else                     r_state <= PH_PLAY;
            end else begin
              r_scan <= r_scan + IDX_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign cell_status_flat = r_cells;
  assign turns_left       = r_turns;
  assign ships_remaining  = r_ships;
  assign game_phase       = r_state;
  assign busy             = r_busy;
  assign hit_pulse        = r_hit;
  assign miss_pulse       = r_miss;
  assign sunk_pulse       = r_sunk;
  assign dup_pulse        = r_dup;

endmodule

// File: tb/tb_battleship_game_core.sv
// Randomised self-checking bench for battleship_game_core on a 4x4 board with a
// rule-level game model (cell array, turn and ship tallies).
module tb_battleship_game_core;

  localparam int ROWS = 4, COLS = 4, NS = 2, ID_W = 3, MT = 6, DB = 4;
  localparam int TURN_W = 5, SHIP_W = 3, N = ROWS * COLS;

  logic                 clk, reset, btn_c, start;
  logic [3:0]           sprite_row, sprite_col;
  logic [N*ID_W-1:0]    ship_map_flat;
  logic [2*N-1:0]       cell_status_flat;
  logic [TURN_W-1:0]    turns_left;
  logic [SHIP_W-1:0]    ships_remaining;
  logic [2:0]           game_phase;
  logic                 busy, hit_pulse, miss_pulse, sunk_pulse, dup_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  int m_map [N];
  int m_cell[N];
  int m_turns, m_ships, m_phase, m_snap_cell, m_snap_turns;
  int water[$];

  logic [3:0] o_pulses;
  int o_npc, o_snap_cell, o_snap_turns;
  bit o_timeout;

  battleship_game_core #(
    .ROWS(ROWS), .COLS(COLS), .NUM_SHIPS(NS), .ID_W(ID_W), .MAX_TURNS(MT),
    .TURN_W(TURN_W), .SHIP_W(SHIP_W), .DB_CYCLES(DB), .AUTO_START(1)
  ) dut (
    .clk(clk), .reset(reset), .btn_c(btn_c), .start(start),
    .sprite_row(sprite_row), .sprite_col(sprite_col), .ship_map_flat(ship_map_flat),
    .cell_status_flat(cell_status_flat), .turns_left(turns_left),
    .ships_remaining(ships_remaining), .game_phase(game_phase), .busy(busy),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .sunk_pulse(sunk_pulse),
    .dup_pulse(dup_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  function automatic void model_new_game();
    m_turns = MT;
    m_ships = 0;
    m_phase = 2;
    foreach (m_cell[i]) m_cell[i] = 0;
    for (int id = 1; id <= NS; id++) begin
      bit present = 0;
      foreach (m_map[i]) if (m_map[i] == id) present = 1;
      if (present) m_ships++;
    end
  endfunction

  // Returns {hit, miss, sunk, dup} and advances the game model by one shot
  function automatic logic [3:0] model_shot(int r, int c);
    int idx, id, left;
    logic [3:0] v;
    v = 4'b0;
    m_snap_cell = -1;
    m_snap_turns = -1;
    if (m_phase != 2 || r >= ROWS || c >= COLS) return v;
    idx = r * COLS + c;
    if (m_cell[idx] != 0) begin
      m_snap_cell = m_cell[idx];
      m_snap_turns = m_turns;
      return 4'b0001;
    end
    id = m_map[idx];
    m_turns = m_turns - 1;
    if (id < 1 || id > NS) begin
      m_cell[idx] = 1;
      v = 4'b0100;
    end else begin
      m_cell[idx] = 2;
      v = 4'b1000;
      left = 0;
      foreach (m_map[i]) if (m_map[i] == id && m_cell[i] == 0) left++;
      if (left == 0) begin
        v[1] = 1'b1;
        m_ships = m_ships - 1;
        foreach (m_map[i]) if (m_map[i] == id) m_cell[i] = 3;
      end
    end
    m_snap_cell = v[2] ? 1 : 2;
    m_snap_turns = m_turns;
    if (m_ships == 0) m_phase = 4;
    else if (m_turns == 0) m_phase = 5;
    return v;
  endfunction

  function automatic logic [2*N-1:0] model_flat();
    logic [2*N-1:0] f;
    for (int i = 0; i < N; i++) f[2*i +: 2] = 2'(m_cell[i]);
    return f;
  endfunction

  task automatic sample_cycle(int idx);
    @(negedge clk);
    if (hit_pulse || miss_pulse || sunk_pulse || dup_pulse) begin
      o_npc++;
      o_pulses = o_pulses | {hit_pulse, miss_pulse, sunk_pulse, dup_pulse};
      o_snap_cell = (idx >= 0) ? int'(cell_status_flat[2*idx +: 2]) : -1;
      o_snap_turns = int'(turns_left);
    end
  endtask

  task automatic do_shot(int r, int c);
    int idx = (r < ROWS && c < COLS) ? r * COLS + c : -1;
    int k = 0;
    sprite_row = 4'(r);
    sprite_col = 4'(c);
    o_pulses = 4'b0; o_npc = 0; o_snap_cell = -1; o_snap_turns = -1; o_timeout = 0;
    btn_c = 1'b1;
    repeat (12) sample_cycle(idx);
    btn_c = 1'b0;
    repeat (12) sample_cycle(idx);
    while (busy && k < 40) begin sample_cycle(idx); k++; end
    if (busy) o_timeout = 1;
  endtask

  task automatic test_reset();
    int bcnt = 0;
    bit saw_load = 0;
    reset = 1'b1; btn_c = 1'b0; start = 1'b0; sprite_row = '0; sprite_col = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({cell_status_flat, turns_left, ships_remaining, game_phase, busy,
         hit_pulse, miss_pulse, sunk_pulse, dup_pulse} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: phase=%0d busy=%b turns=%0d ships=%0d cells=%h, required all zero",
               game_phase, busy, turns_left, ships_remaining, cell_status_flat);
    end
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (game_phase == 3'd1) saw_load = 1;
      if (game_phase == 3'd2) break;
    end
    model_new_game();
    n_tests++;
    if (bcnt != N || !saw_load || game_phase !== 3'd2 || turns_left !== TURN_W'(m_turns) ||
        ships_remaining !== SHIP_W'(m_ships) || cell_status_flat !== '0) begin
      n_fail++;
      $display("FAIL reset_load: busy_cycles=%0d load_seen=%b phase=%0d turns=%0d ships=%0d cells=%h, required %0d/1/2/%0d/%0d/0",
               bcnt, saw_load, game_phase, turns_left, ships_remaining, cell_status_flat, N, m_turns, m_ships);
    end
  endtask

  task automatic test_restart(string tag);
    int bcnt = 0;
    start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start = (k == 4);
      if (busy) bcnt++;
      if (game_phase == 3'd2) break;
    end
    start = 1'b0;
    model_new_game();
    n_tests++;
    if (bcnt != N || game_phase !== 3'd2 || turns_left !== TURN_W'(m_turns) ||
        ships_remaining !== SHIP_W'(m_ships) || cell_status_flat !== '0) begin
      n_fail++;
      $display("FAIL restart_%s: busy_cycles=%0d phase=%0d turns=%0d ships=%0d cells=%h, required %0d/2/%0d/%0d/0",
               tag, bcnt, game_phase, turns_left, ships_remaining, cell_status_flat, N, m_turns, m_ships);
    end
  endtask

  task automatic test_miss_dup();
    int rs[2] = '{0, 0};
    int cs[2] = '{2, 2};
    for (int s = 0; s < 2; s++) begin
      logic [3:0] e = model_shot(rs[s], cs[s]);
      do_shot(rs[s], cs[s]);
      n_tests++;
      if (o_pulses !== e || o_npc != (e != 0) || o_snap_cell != m_snap_cell || o_snap_turns != m_snap_turns) begin
        n_fail++;
        $display("FAIL miss_dup_event%0d: pulses=%b n=%0d cell=%0d turns=%0d, required %b/%0d/%0d/%0d",
                 s, o_pulses, o_npc, o_snap_cell, o_snap_turns, e, (e != 0), m_snap_cell, m_snap_turns);
      end
      n_tests++;
      if (o_timeout || cell_status_flat !== model_flat() || turns_left !== TURN_W'(m_turns) ||
          ships_remaining !== SHIP_W'(m_ships) || game_phase !== 3'(m_phase)) begin
        n_fail++;
        $display("FAIL miss_dup_state%0d: cells=%h turns=%0d ships=%0d phase=%0d, required %h/%0d/%0d/%0d",
                 s, cell_status_flat, turns_left, ships_remaining, game_phase, model_flat(), m_turns, m_ships, m_phase);
      end
    end
  endtask

  task automatic test_sink_win(string tag, int rs[$], int cs[$]);
    foreach (rs[s]) begin
      logic [3:0] e = model_shot(rs[s], cs[s]);
      do_shot(rs[s], cs[s]);
      n_tests++;
      if (o_pulses !== e || o_npc != (e != 0) || o_snap_cell != m_snap_cell || o_snap_turns != m_snap_turns) begin
        n_fail++;
        $display("FAIL %s_event%0d: pulses=%b n=%0d cell=%0d turns=%0d, required %b/%0d/%0d/%0d",
                 tag, s, o_pulses, o_npc, o_snap_cell, o_snap_turns, e, (e != 0), m_snap_cell, m_snap_turns);
      end
      n_tests++;
      if (o_timeout || cell_status_flat !== model_flat() || turns_left !== TURN_W'(m_turns) ||
          ships_remaining !== SHIP_W'(m_ships) || game_phase !== 3'(m_phase) || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_state%0d: cells=%h turns=%0d ships=%0d phase=%0d busy=%b, required %h/%0d/%0d/%0d/0",
                 tag, s, cell_status_flat, turns_left, ships_remaining, game_phase, busy,
                 model_flat(), m_turns, m_ships, m_phase);
      end
    end
  endtask

  task automatic test_lose();
    int off = $urandom_range(0, water.size() - 1);
    int rs[$], cs[$];
    for (int i = 0; i < MT; i++) begin
      int w = water[(off + i) % water.size()];
      rs.push_back(w / COLS);
      cs.push_back(w % COLS);
    end
    rs.push_back(0); cs.push_back(0);
    test_sink_win("lose", rs, cs);
    n_tests++;
    if (game_phase !== 3'd5 || turns_left !== '0) begin
      n_fail++;
      $display("FAIL lose_phase: phase=%0d turns=%0d, required 5/0", game_phase, turns_left);
    end
  endtask

  task automatic test_glitch();
    int seen = 0;
    sprite_row = 4'd0; sprite_col = 4'd3;
    for (int g = 0; g < 5; g++) begin
      int len = $urandom_range(1, 3);
      btn_c = 1'b1;
      repeat (len) begin @(negedge clk); if (hit_pulse | miss_pulse | sunk_pulse | dup_pulse) seen++; end
      btn_c = 1'b0;
      repeat (8) begin @(negedge clk); if (hit_pulse | miss_pulse | sunk_pulse | dup_pulse) seen++; end
    end
    n_tests++;
    if (seen != 0 || turns_left !== TURN_W'(m_turns) || cell_status_flat !== model_flat()) begin
      n_fail++;
      $display("FAIL glitch: pulses=%0d turns=%0d cells=%h, required 0/%0d/%h",
               seen, turns_left, cell_status_flat, m_turns, model_flat());
    end
  endtask

  task automatic test_out_of_range();
    int rs[$], cs[$];
    rs.push_back(5); cs.push_back($urandom_range(0, COLS - 1));
    rs.push_back($urandom_range(0, ROWS - 1)); cs.push_back(COLS + $urandom_range(0, 11));
    test_sink_win("oor", rs, cs);
  endtask

  task automatic test_reset_mid_sink();
    int k = 0;
    int rs[$] = '{0};
    int cs[$] = '{0};
    test_sink_win("pre_abort", rs, cs);
    sprite_row = 4'd0; sprite_col = 4'd1;
    btn_c = 1'b1;
    while (!sunk_pulse && k < 30) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    n_tests++;
    if (game_phase !== 3'd3 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_in_sink: phase=%0d busy=%b, required 3/1", game_phase, busy);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({cell_status_flat, turns_left, ships_remaining, game_phase, busy,
         hit_pulse, miss_pulse, sunk_pulse, dup_pulse} !== '0) begin
      n_fail++;
      $display("FAIL abort_reset: phase=%0d busy=%b turns=%0d ships=%0d cells=%h, required all zero",
               game_phase, busy, turns_left, ships_remaining, cell_status_flat);
    end
    btn_c = 1'b0;
  endtask

  initial begin
    reset = 1'b1; btn_c = 1'b0; start = 1'b0; sprite_row = '0; sprite_col = '0;
    foreach (m_map[i]) m_map[i] = 0;
    m_map[0] = 1; m_map[1] = 1;
    m_map[5] = 2; m_map[9] = 2; m_map[13] = 2;
    foreach (m_map[i]) begin
      ship_map_flat[i*ID_W +: ID_W] = ID_W'(m_map[i]);
      if (m_map[i] == 0) water.push_back(i);
    end

    test_reset();
    test_miss_dup();
    test_sink_win("sink", '{0, 0}, '{0, 1});
    test_sink_win("win", '{1, 2, 3, 0}, '{1, 1, 1, 3});
    test_restart("after_win");
    test_lose();
    test_restart("after_lose");
    test_glitch();
    test_out_of_range();
    test_reset_mid_sink();
    test_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/battleship_game_core.md
Name: battleship_game_core

Overview:
- Parametrised successor to the fixed 10x10 game-state engine that sits between cursor control and the renderer/SSD path in the VGA battleship top.
- Generalised in grid size, ship count and turn budget.
- Takes a per-cell ship-ID map and debounces the fire button internally.
- Tracks hits per ship and marks whole ships as sunk by scanning the grid.
- Drives an explicit IDLE/LOAD/PLAY/SINK/WIN/LOSE state machine, with event pulses for the SSD/audio logic.

Parameters:
ROWS, 10, grid rows
COLS, 10, grid columns
NUM_SHIPS, 5, max ship IDs honoured (IDs 1..NUM_SHIPS)
ID_W, 3, bits per ship-ID map entry
MAX_TURNS, 20, shots per game
TURN_W, 5, width of turns_left
SHIP_W, 3, width of ships_remaining
DB_CYCLES, 1000000, cycles the fire input must be stable
AUTO_START, 1, 1 = enter LOAD automatically after reset

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
btn_c  in  1  raw fire button (asynchronous to clk)
start  in  1  single-cycle new-game request
sprite_row  in  4  cursor row
sprite_col  in  4  cursor column
ship_map_flat  in  ROWS*COLS*ID_W  ship ID per cell; 0 = water; cell i at [i*ID_W +: ID_W]
cell_status_flat  out  2*ROWS*COLS  per-cell code, cell i = row*COLS+col
turns_left  out  TURN_W  shots remaining
ships_remaining  out  SHIP_W  unsunk ships
game_phase  out  3  current FSM state
busy  out  1  high in LOAD or SINK
hit_pulse, miss_pulse, sunk_pulse, dup_pulse  out  1 each  one-cycle event strobes

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; per-ship counters 0.
- Cell codes: 00 unknown, 01 miss, 10 hit, 11 sunk.
- Fire path:
  - 2-flop synchroniser, then debounce: the stable level is updated only after DB_CYCLES consecutive identical samples.
  - A rising edge of the stable level produces a one-cycle fire_evt.
  - fire_evt outside PLAY is dropped, not queued.
- IDLE -> LOAD on start, or on the first clock after reset release if AUTO_START=1.
- Start from PLAY/WIN/LOSE/SINK -> LOAD (restart). Start during LOAD is ignored.
- LOAD:
  - Latches ship_map_flat on entry.
  - Clears cell_status_flat and sets turns_left=MAX_TURNS.
  - Scans one cell per cycle (ROWS*COLS cycles), incrementing cnt[id] for id in 1..NUM_SHIPS; IDs 0 or >NUM_SHIPS are water.
  - On the final cycle, ships_remaining = number of ids with cnt>0, then -> PLAY.
- PLAY, on fire_evt, with idx = sprite_row*COLS+sprite_col:
  - Cursor out of range (row>=ROWS or col>=COLS): ignored; no turn used; no pulse.
  - Cell already non-00: dup_pulse; no turn used.
  - Water: cell=01, turns_left-1, miss_pulse.
  - Ship id: cell=10, turns_left-1, cnt[id]-1, hit_pulse.
  - If cnt[id] reaches 0: ships_remaining-1, sunk_pulse and hit_pulse in the same cycle, latch sink_id, -> SINK.
  - Otherwise, after the update: ships_remaining==0 -> WIN; turns_left==0 -> LOSE; else stay in PLAY.
  - All updates and pulses appear on the clock edge following fire_evt (1-cycle latency).
- SINK:
  - Scans all cells, one per cycle.
  - Any cell whose latched ID == sink_id becomes 11.
  - After the last cell: ships_remaining==0 -> WIN (win has priority when the final turn sinks the final ship); else turns_left==0 -> LOSE; else PLAY.
- WIN/LOSE: hold all outputs; only start leaves.
- game_phase encoding: IDLE 0, LOAD 1, PLAY 2, SINK 3, WIN 4, LOSE 5.
- Arithmetic: turns_left and ships_remaining never underflow; cnt width = clog2(ROWS*COLS+1).
- Reset mid-LOAD or mid-SINK aborts immediately to IDLE with all outputs 0.

Decomposition:
- battleship_pkg holds:
  - cell codes CELL_UNKNOWN/MISS/HIT/SUNK;
  - phase encodings;
  - a clog2 helper.
- One sub-module, btn_debounce_edge (params DB_CYCLES; ports clk, reset, btn_raw, press_pulse): contains the synchroniser, debounce and edge detector.
- FSM, scan counter and ship counters stay in battleship_game_core.

Test Plan:
- Common config for all scenarios: ROWS=4, COLS=4, NUM_SHIPS=2, MAX_TURNS=6, DB_CYCLES=4, AUTO_START=1.
- Map: ship1 at cells 0,1; ship2 at cells 5,9,13.
1. Reset release -> busy high for 16 cycles -> PLAY with turns_left=6, ships_remaining=2, cell_status_flat=0.
2. Fire at (0,2) -> next cycle cell2=01, miss_pulse, turns_left=5. Fire again at (0,2) -> dup_pulse, turns_left stays 5.
3. Fire at (0,0), then (0,1) -> hit_pulse each; on the second, sunk_pulse and ships_remaining=1. After the SINK scan, cells 0 and 1 both read 11 and phase=PLAY.
4. Hit cells 5, 9, 13 with exactly the last remaining turns -> ships_remaining=0, turns_left=0. After SINK, phase=WIN, not LOSE.
5. Six misses -> turns_left=0, phase=LOSE. A further fire_evt changes nothing. A start pulse -> LOAD, and the cleared board is restored.
6. Glitchy btn_c (3-cycle high pulses) -> no event. Cursor at row=5 -> shot ignored, turns unchanged. Reset asserted mid-SINK -> IDLE with all outputs 0.
